// File: rtl/amaster_pkg.sv
// Shared types and sizing helpers for the Avalon-MM style register master.
// The top module and the wait timer import this package.
package amaster_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    XFER = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int DEF_ADDRW   = 8;
  localparam int DEF_DATAW   = 32;
  localparam int DEF_TIMEOUT = 255;

  function automatic int calc_bew(input int dataw);
    return dataw / 8;
  endfunction

  // The counter only ever reaches TIMEOUT-1, so clog2(TIMEOUT+1) bits always suffice.
  function automatic int calc_cntw(input int timeout);
    return (timeout < 1) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/amaster_wait_timer.sv
// Per-transfer stall counter: cleared on command accept, counts stalled cycles,
// and saturates at TIMEOUT-1, where it flags expiry.
module amaster_wait_timer
  import amaster_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int CNTW    = calc_cntw(TIMEOUT)
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic stall,
  output logic expired
);

  localparam logic [CNTW-1:0] LAST = CNTW'(TIMEOUT - 1);

  logic [CNTW-1:0] count;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      count <= '0;
    end else if (stall && (count != LAST)) begin
      count <= count + 1'b1;
    end
  end

  assign expired = (count == LAST);

endmodule

// File: rtl/amaster_mm.sv
// Avalon-MM style master: one registered read or write bus transfer per accepted
// command, waitrequest-aware, with a bounded-wait timeout and a one-cycle response.
module amaster_mm
  import amaster_pkg::*;
#(
  parameter int ADDRW   = DEF_ADDRW,
  parameter int DATAW   = DEF_DATAW,
  parameter int BEW     = calc_bew(DATAW),
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_write,
  input  logic [ADDRW-1:0] cmd_addr,
  input  logic [DATAW-1:0] cmd_wdata,
  input  logic [BEW-1:0]   cmd_byteenable,
  output logic [ADDRW-1:0] ms_addr,
  output logic             ms_read,
  output logic             ms_write,
  output logic [DATAW-1:0] ms_writedata,
  output logic [BEW-1:0]   ms_byteenable,
  input  logic [DATAW-1:0] ms_readdata,
  input  logic             ms_waitrequest,
  output logic             rsp_valid,
  output logic [DATAW-1:0] rsp_rdata,
  output logic             rsp_err,
  output logic             busy
);

  state_t         state;
  logic           accept;
  logic           stall;
  logic           expired;
  logic [BEW-1:0] be_in;

  assign accept = (state == IDLE) && cmd_valid;
  assign stall  = (state == XFER) && ms_waitrequest;

  // A byte-wide bus has only one lane, so it is always enabled.
  assign be_in = (DATAW == 8) ? {BEW{1'b1}} : cmd_byteenable;

  amaster_wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .stall   (stall),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      cmd_ready     <= 1'b1;
      busy          <= 1'b0;
      ms_addr       <= '0;
      ms_read       <= 1'b0;
      ms_write      <= 1'b0;
      ms_writedata  <= '0;
      ms_byteenable <= '0;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      rsp_err       <= 1'b0;
    end else begin
      rsp_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (cmd_valid) begin
            ms_addr       <= cmd_addr;
            ms_writedata  <= cmd_wdata;
            ms_byteenable <= be_in;
            ms_write      <= cmd_write;
            ms_read       <= !cmd_write;
            cmd_ready     <= 1'b0;
            busy          <= 1'b1;
            state         <= XFER;
          end
        end
        XFER: begin
          // Completion is checked first so a release on the last allowed cycle is not an error.
          if (!ms_waitrequest) begin
            rsp_rdata <= ms_read ? ms_readdata : '0;
            rsp_err   <= 1'b0;
            ms_read   <= 1'b0;
            ms_write  <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (expired) begin
            rsp_rdata <= '0;
            rsp_err   <= 1'b1;
            ms_read   <= 1'b0;
            ms_write  <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
        default: begin
          cmd_ready <= 1'b1;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_amaster_mm.sv
// Self-checking bench for amaster_mm: directed protocol steps plus randomized
// commands scored against a transaction-level model of latency and response.
module tb_amaster_mm;

  localparam int ADDRW   = 8;
  localparam int DATAW   = 32;
  localparam int TIMEOUT = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [7:0]  cmd_addr;
  logic [31:0] cmd_wdata;
  logic [3:0]  cmd_byteenable;
  logic [7:0]  ms_addr;
  logic        ms_read, ms_write;
  logic [31:0] ms_writedata;
  logic [3:0]  ms_byteenable;
  logic [31:0] ms_readdata;
  logic        ms_waitrequest;
  logic        rsp_valid, rsp_err, busy;
  logic [31:0] rsp_rdata;

  logic        cmd_valid8, cmd_ready8, cmd_write8;
  logic [7:0]  cmd_addr8, cmd_wdata8, ms_addr8, ms_writedata8, ms_readdata8, rsp_rdata8;
  logic [0:0]  cmd_byteenable8, ms_byteenable8;
  logic        ms_read8, ms_write8, ms_waitrequest8, rsp_valid8, rsp_err8, busy8;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk = ~clk;

  amaster_mm #(.ADDRW(ADDRW), .DATAW(DATAW), .TIMEOUT(TIMEOUT)) u_dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_byteenable(cmd_byteenable),
    .ms_addr(ms_addr), .ms_read(ms_read), .ms_write(ms_write),
    .ms_writedata(ms_writedata), .ms_byteenable(ms_byteenable),
    .ms_readdata(ms_readdata), .ms_waitrequest(ms_waitrequest),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .busy(busy)
  );

  amaster_mm #(.ADDRW(8), .DATAW(8), .TIMEOUT(TIMEOUT)) u_dut8 (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid8), .cmd_ready(cmd_ready8), .cmd_write(cmd_write8),
    .cmd_addr(cmd_addr8), .cmd_wdata(cmd_wdata8), .cmd_byteenable(cmd_byteenable8),
    .ms_addr(ms_addr8), .ms_read(ms_read8), .ms_write(ms_write8),
    .ms_writedata(ms_writedata8), .ms_byteenable(ms_byteenable8),
    .ms_readdata(ms_readdata8), .ms_waitrequest(ms_waitrequest8),
    .rsp_valid(rsp_valid8), .rsp_rdata(rsp_rdata8), .rsp_err(rsp_err8), .busy(busy8)
  );

  // Expected outcome of one command, derived from the wait-state count alone.
  typedef struct packed {
    int unsigned strobe_cycles;
    logic        err;
    logic [31:0] rdata;
  } exp_t;

  function automatic exp_t model(input bit wr, input int waits, input logic [31:0] rd);
    exp_t e;
    if (waits >= TIMEOUT) begin
      e.strobe_cycles = TIMEOUT;
      e.err           = 1'b1;
      e.rdata         = '0;
    end else begin
      e.strobe_cycles = waits + 1;
      e.err           = 1'b0;
      e.rdata         = wr ? 32'h0 : rd;
    end
    return e;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issues one command at posedge+1 and follows it cycle by cycle to the response.
  task automatic run_cmd(input bit wr, input logic [7:0] addr, input logic [31:0] wd,
                         input logic [3:0] be, input int waits, input logic [31:0] rd,
                         input string tag);
    exp_t e;
    int   guard;
    e     = model(wr, waits, rd);
    guard = 0;
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wd; cmd_byteenable = be;
    while (!cmd_ready && guard < 20) begin
      tick();
      guard++;
    end
    check($sformatf("%s.ready", tag), cmd_ready, 1);
    tick();
    cmd_valid = 1'b0; cmd_addr = 8'($urandom()); cmd_wdata = $urandom();
    cmd_byteenable = 4'($urandom());
    for (int k = 1; k <= int'(e.strobe_cycles); k++) begin
      check($sformatf("%s.wr%0d", tag, k), ms_write, wr);
      check($sformatf("%s.rd%0d", tag, k), ms_read, !wr);
      check($sformatf("%s.addr%0d", tag, k), ms_addr, addr);
      check($sformatf("%s.nrsp%0d", tag, k), rsp_valid, 0);
      check($sformatf("%s.nrdy%0d", tag, k), cmd_ready, 0);
      if (wr) begin
        check($sformatf("%s.wd%0d", tag, k), ms_writedata, wd);
        check($sformatf("%s.be%0d", tag, k), ms_byteenable, be);
      end
      ms_waitrequest = (k <= waits);
      ms_readdata    = (k <= waits) ? $urandom() : rd;
      tick();
    end
    ms_waitrequest = 1'b0;
    ms_readdata    = $urandom();
    check($sformatf("%s.strobe_off", tag), {ms_read, ms_write}, 0);
    check($sformatf("%s.rsp", tag), rsp_valid, 1);
    check($sformatf("%s.err", tag), rsp_err, e.err);
    check($sformatf("%s.rdata", tag), rsp_rdata, e.rdata);
    check($sformatf("%s.resp_nrdy", tag), cmd_ready, 0);
    tick();
    check($sformatf("%s.rsp_pulse", tag), rsp_valid, 0);
    check($sformatf("%s.ready_back", tag), cmd_ready, 1);
    check($sformatf("%s.idle", tag), busy, 0);
    check($sformatf("%s.rdata_hold", tag), rsp_rdata, e.rdata);
    check($sformatf("%s.err_hold", tag), rsp_err, e.err);
  endtask

  initial begin
    int acc[$];
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_byteenable = '0;
    ms_readdata = '0; ms_waitrequest = 1'b0;
    cmd_valid8 = 1'b0; cmd_write8 = 1'b0; cmd_addr8 = '0; cmd_wdata8 = '0;
    cmd_byteenable8 = '0; ms_readdata8 = '0; ms_waitrequest8 = 1'b0;
    repeat (3) tick();

    check("rst.ready", cmd_ready, 1);
    check("rst.busy", busy, 0);
    check("rst.strobes", {ms_read, ms_write}, 0);
    check("rst.addr", ms_addr, 0);
    check("rst.wdata", ms_writedata, 0);
    check("rst.be", ms_byteenable, 0);
    check("rst.rsp", {rsp_valid, rsp_err}, 0);
    check("rst.rdata", rsp_rdata, 0);
    check("rst.ready8", cmd_ready8, 1);
    rst = 1'b0;
    tick();

    run_cmd(1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 0, 32'h0, "wr0");
    run_cmd(1'b0, 8'h24, 32'h0, 4'hF, 3, 32'h12345678, "rd3");
    run_cmd(1'b0, 8'h33, 32'h0, 4'h3, 10, 32'hAAAA5555, "timeout");
    run_cmd(1'b1, 8'h34, 32'hCAFEF00D, 4'h0, 1, 32'h0, "after_to");
    run_cmd(1'b1, 8'h40, 32'h01020304, 4'h5, 4, 32'h0, "wr_to_edge");

    for (int i = 0; i < 20; i++) begin
      run_cmd(1'($urandom_range(0, 1)), 8'($urandom()), $urandom(),
              4'($urandom_range(0, 15)), int'($urandom_range(0, 6)), $urandom(),
              $sformatf("rnd%0d", i));
    end

    // Back-to-back reads with cmd_valid held: accepts land every third cycle.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h55; ms_waitrequest = 1'b0;
    ms_readdata = 32'h0BADF00D;
    for (int c = 0; c < 8; c++) begin
      check($sformatf("b2b.excl%0d", c), ms_read & ms_write, 0);
      if (c <= 6) begin
        check($sformatf("b2b.ready%0d", c), cmd_ready, (c % 3 == 0));
        check($sformatf("b2b.read%0d", c), ms_read, (c % 3 == 1));
      end
      if (cmd_valid && cmd_ready) acc.push_back(c);
      tick();
      if (acc.size() == 2) cmd_valid = 1'b0;
    end
    check("b2b.count", acc.size(), 2);
    if (acc.size() == 2) check("b2b.spacing", acc[1] - acc[0], 3);

    // Reset during a stalled read.
    cmd_valid = 1'b1; cmd_write = 1'b0; cmd_addr = 8'h66; ms_waitrequest = 1'b1;
    tick();
    cmd_valid = 1'b0;
    tick();
    tick();
    check("midrst.pre_read", ms_read, 1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    ms_waitrequest = 1'b0;
    check("midrst.read", ms_read, 0);
    check("midrst.busy", busy, 0);
    check("midrst.ready", cmd_ready, 1);
    check("midrst.rsp", rsp_valid, 0);
    tick();
    check("midrst.no_rsp", rsp_valid, 0);
    check("midrst.still_idle", ms_read, 0);
    run_cmd(1'b0, 8'h67, 32'h0, 4'hF, 2, 32'h5A5AA5A5, "post_rst");

    // Byte-wide build: a zero byteenable still drives the single lane.
    cmd_valid8 = 1'b1; cmd_write8 = 1'b1; cmd_addr8 = 8'h5A; cmd_wdata8 = 8'hC3;
    cmd_byteenable8 = 1'b0; ms_waitrequest8 = 1'b0;
    tick();
    cmd_valid8 = 1'b0;
    check("dw8.write", ms_write8, 1);
    check("dw8.read", ms_read8, 0);
    check("dw8.be", ms_byteenable8, 1);
    check("dw8.addr", ms_addr8, 8'h5A);
    check("dw8.wdata", ms_writedata8, 8'hC3);
    check("dw8.busy", busy8, 1);
    tick();
    check("dw8.rsp", rsp_valid8, 1);
    check("dw8.err", rsp_err8, 0);
    check("dw8.rdata", rsp_rdata8, 0);
    tick();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
